// File: rtl/game_pkg.sv
// Shared state encoding and default timing for the duck-round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INTRO,
    FLIGHT,
    KILLED,
    ESCAPED,
    PAUSE,
    DONE
  } round_state_t;

  localparam int ROUNDS_DEFAULT          = 10;
  localparam int FLIGHT_CYCLES_DEFAULT   = 390_000_000;
  localparam int DOG_BIRD_CYCLES_DEFAULT = 130_000_000;
  localparam int PAUSE_CYCLES_DEFAULT    = 65_000_000;

  localparam logic [6:0] SCORE_MAX = 7'd99;

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter shared by the flight, celebration and pause phases.
module round_timer #(
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the counter parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/round_sequencer.sv
// Sequences a game session of duck rounds: intro, flight, kill/escape, pause.
module round_sequencer
  import game_pkg::*;
#(
  parameter int ROUNDS          = ROUNDS_DEFAULT,
  parameter int FLIGHT_CYCLES   = FLIGHT_CYCLES_DEFAULT,
  parameter int DOG_BIRD_CYCLES = DOG_BIRD_CYCLES_DEFAULT,
  parameter int PAUSE_CYCLES    = PAUSE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic       game_enable_posedge,
  input  logic       dog_intro_done,
  input  logic       duck_killed,
  input  logic       out_of_ammo,
  output logic       hunt_start,
  output logic       dog_bird_enable,
  output logic       duck_escaped,
  output logic [6:0] enemy_score,
  output logic [6:0] round_number,
  output logic       game_finished
);

  if (FLIGHT_CYCLES <= 0 || DOG_BIRD_CYCLES <= 0 || PAUSE_CYCLES <= 0) begin : g_bad_cycles
    $error("round_sequencer: cycle parameters must be non-zero");
  end
  if (ROUNDS < 1 || ROUNDS > 99) begin : g_bad_rounds
    $error("round_sequencer: ROUNDS must be in 1..99");
  end
  if (CNT_WIDTH < 32 && (((FLIGHT_CYCLES - 1) >> CNT_WIDTH) != 0 ||
      ((DOG_BIRD_CYCLES - 1) >> CNT_WIDTH) != 0 ||
      ((PAUSE_CYCLES - 1) >> CNT_WIDTH) != 0)) begin : g_bad_width
    $error("round_sequencer: CNT_WIDTH too small for cycle parameters");
  end

  localparam logic [CNT_WIDTH-1:0] FLIGHT_LOAD = CNT_WIDTH'(FLIGHT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DOG_LOAD    = CNT_WIDTH'(DOG_BIRD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PAUSE_LOAD  = CNT_WIDTH'(PAUSE_CYCLES - 1);

  round_state_t         state;
  logic                 timer_load;
  logic [CNT_WIDTH-1:0] timer_value;
  logic                 timer_en;
  logic                 timer_zero;
  logic                 last_round;

  assign last_round = (round_number == 7'(ROUNDS));
  assign timer_en   = (state == FLIGHT) || (state == KILLED) || (state == PAUSE);

  // Timer reloads coincide with the phase transitions taken in the FSM below.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      INTRO:   if (dog_intro_done) begin timer_load = 1'b1; timer_value = FLIGHT_LOAD; end
      FLIGHT:  if (duck_killed)    begin timer_load = 1'b1; timer_value = DOG_LOAD;    end
      KILLED:  if (timer_zero)     begin timer_load = 1'b1; timer_value = PAUSE_LOAD;  end
      ESCAPED: begin timer_load = 1'b1; timer_value = PAUSE_LOAD; end
      PAUSE:   if (timer_zero && !(last_round || out_of_ammo)) begin
                 timer_load  = 1'b1;
                 timer_value = FLIGHT_LOAD;
               end
      default: ;
    endcase
  end

  round_timer #(.WIDTH(CNT_WIDTH)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .en         (timer_en),
    .zero       (timer_zero)
  );

  // Leaving the game keeps enemy_score for the end screen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      hunt_start      <= 1'b0;
      dog_bird_enable <= 1'b0;
      duck_escaped    <= 1'b0;
      game_finished   <= 1'b0;
      enemy_score     <= '0;
      round_number    <= '0;
    end else if (state != IDLE && !game_enable) begin
      state           <= IDLE;
      hunt_start      <= 1'b0;
      dog_bird_enable <= 1'b0;
      duck_escaped    <= 1'b0;
      game_finished   <= 1'b0;
      round_number    <= '0;
    end else begin
      duck_escaped <= 1'b0;
      case (state)
        IDLE: if (game_enable_posedge) begin
          enemy_score  <= '0;
          round_number <= 7'd1;
          state        <= INTRO;
        end
        INTRO: if (dog_intro_done) begin
          hunt_start <= 1'b1;
          state      <= FLIGHT;
        end
        FLIGHT: if (duck_killed) begin
          hunt_start      <= 1'b0;
          dog_bird_enable <= 1'b1;
          state           <= KILLED;
        end else if (timer_zero || out_of_ammo) begin
          hunt_start   <= 1'b0;
          duck_escaped <= 1'b1;
          if (enemy_score < SCORE_MAX) enemy_score <= enemy_score + 7'd1;
          state        <= ESCAPED;
        end
        KILLED: if (timer_zero) begin
          dog_bird_enable <= 1'b0;
          state           <= PAUSE;
        end
        ESCAPED: state <= PAUSE;
        PAUSE: if (timer_zero) begin
          if (last_round || out_of_ammo) begin
            game_finished <= 1'b1;
            state         <= DONE;
          end else begin
            round_number <= round_number + 7'd1;
            hunt_start   <= 1'b1;
            state        <= FLIGHT;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench: a phase/duration model predicts every cycle's outputs.
module tb_round_sequencer;

  localparam int ROUNDS = 3;
  localparam int FLIGHT = 20;
  localparam int DOG    = 8;
  localparam int PAUSE  = 4;

  logic       clk;
  logic       rst;
  logic       game_enable;
  logic       game_enable_posedge;
  logic       dog_intro_done;
  logic       duck_killed;
  logic       out_of_ammo;
  logic       hunt_start;
  logic       dog_bird_enable;
  logic       duck_escaped;
  logic [6:0] enemy_score;
  logic [6:0] round_number;
  logic       game_finished;

  round_sequencer #(
    .ROUNDS          (ROUNDS),
    .FLIGHT_CYCLES   (FLIGHT),
    .DOG_BIRD_CYCLES (DOG),
    .PAUSE_CYCLES    (PAUSE),
    .CNT_WIDTH       (29)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .game_enable         (game_enable),
    .game_enable_posedge (game_enable_posedge),
    .dog_intro_done      (dog_intro_done),
    .duck_killed         (duck_killed),
    .out_of_ammo         (out_of_ammo),
    .hunt_start          (hunt_start),
    .dog_bird_enable     (dog_bird_enable),
    .duck_escaped        (duck_escaped),
    .enemy_score         (enemy_score),
    .round_number        (round_number),
    .game_finished       (game_finished)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {PH_IDLE, PH_INTRO, PH_FLY, PH_CELEBRATE, PH_ESCAPE, PH_REST, PH_OVER} phase_t;

  typedef struct {
    int hunt;
    int dog;
    int esc;
    int fin;
    int score;
    int round;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  phase_t m_phase;
  int     m_left;
  int     m_score;
  int     m_round;
  int     checks;
  int     errors;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  // m_left counts the cycles still to be spent in the current phase, this one included.
  task automatic model_step();
    exp_t e;
    if (rst) begin
      m_phase = PH_IDLE;
      m_score = 0;
      m_round = 0;
      m_left  = 0;
    end else if (m_phase != PH_IDLE && !game_enable) begin
      m_phase = PH_IDLE;
      m_round = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (game_enable_posedge) begin
          m_score = 0;
          m_round = 1;
          m_phase = PH_INTRO;
        end
        PH_INTRO: if (dog_intro_done) begin
          m_phase = PH_FLY;
          m_left  = FLIGHT;
        end
        PH_FLY: begin
          if (duck_killed) begin
            m_phase = PH_CELEBRATE;
            m_left  = DOG;
          end else if (m_left == 1 || out_of_ammo) begin
            m_phase = PH_ESCAPE;
            m_score = (m_score < 99) ? m_score + 1 : 99;
          end else begin
            m_left--;
          end
        end
        PH_CELEBRATE: begin
          if (m_left == 1) begin
            m_phase = PH_REST;
            m_left  = PAUSE;
          end else begin
            m_left--;
          end
        end
        PH_ESCAPE: begin
          m_phase = PH_REST;
          m_left  = PAUSE;
        end
        PH_REST: begin
          if (m_left == 1) begin
            if (m_round == ROUNDS || out_of_ammo) begin
              m_phase = PH_OVER;
            end else begin
              m_round++;
              m_phase = PH_FLY;
              m_left  = FLIGHT;
            end
          end else begin
            m_left--;
          end
        end
        default: ;
      endcase
    end
    e.hunt  = (m_phase == PH_FLY) ? 1 : 0;
    e.dog   = (m_phase == PH_CELEBRATE) ? 1 : 0;
    e.esc   = (m_phase == PH_ESCAPE) ? 1 : 0;
    e.fin   = (m_phase == PH_OVER) ? 1 : 0;
    e.score = m_score;
    e.round = m_round;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic run_until_phase(input phase_t target, input int limit);
    int spent;
    spent = 0;
    while (m_phase != target && spent < limit) begin
      apply_stimulus(1);
      spent++;
    end
    if (m_phase != target) check_output("phase_timeout", int'(m_phase), int'(target));
  endtask

  task automatic run_until_last_flight_cycle(input int limit);
    int spent;
    spent = 0;
    while (!(m_phase == PH_FLY && m_left == 1) && spent < limit) begin
      apply_stimulus(1);
      spent++;
    end
    if (!(m_phase == PH_FLY && m_left == 1)) check_output("flight_end_timeout", m_left, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_hunt"},  int'(hunt_start), 0);
    check_output({tag, "_dog"},   int'(dog_bird_enable), 0);
    check_output({tag, "_esc"},   int'(duck_escaped), 0);
    check_output({tag, "_fin"},   int'(game_finished), 0);
    check_output({tag, "_score"}, int'(enemy_score), 0);
    check_output({tag, "_round"}, int'(round_number), 0);
  endtask

  // Monitor: one predicted output set per rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output("hunt_start",      int'(hunt_start),      mon_e.hunt);
      check_output("dog_bird_enable", int'(dog_bird_enable), mon_e.dog);
      check_output("duck_escaped",    int'(duck_escaped),    mon_e.esc);
      check_output("game_finished",   int'(game_finished),   mon_e.fin);
      check_output("enemy_score",     int'(enemy_score),     mon_e.score);
      check_output("round_number",    int'(round_number),    mon_e.round);
    end
  end

  initial begin
    checks              = 0;
    errors              = 0;
    m_phase             = PH_IDLE;
    m_left              = 0;
    m_score             = 0;
    m_round             = 0;
    rst                 = 1'b1;
    game_enable         = 1'b0;
    game_enable_posedge = 1'b0;
    dog_intro_done      = 1'b0;
    duck_killed         = 1'b0;
    out_of_ammo         = 1'b0;
    @(negedge clk);
    apply_stimulus(2);
    check_all_zero("reset");
    rst = 1'b0;

    // Round 1 escapes on timeout, round 2 begins after the pause.
    game_enable = 1'b1;
    game_enable_posedge = 1'b1; apply_stimulus(1); game_enable_posedge = 1'b0;
    check_output("s1_round_start", int'(round_number), 1);
    apply_stimulus(3);
    check_output("s1_no_hunt_in_intro", int'(hunt_start), 0);
    dog_intro_done = 1'b1; apply_stimulus(1); dog_intro_done = 1'b0;
    check_output("s1_hunt_rise", int'(hunt_start), 1);
    apply_stimulus(19);
    check_output("s1_hunt_last", int'(hunt_start), 1);
    apply_stimulus(1);
    check_output("s1_escape_pulse", int'(duck_escaped), 1);
    check_output("s1_score", int'(enemy_score), 1);
    check_output("s1_hunt_fall", int'(hunt_start), 0);
    apply_stimulus(1);
    check_output("s1_escape_once", int'(duck_escaped), 0);
    apply_stimulus(4);
    check_output("s1_round2", int'(round_number), 2);
    check_output("s1_round2_hunt", int'(hunt_start), 1);

    // Kill ten cycles into round 2.
    apply_stimulus(9);
    duck_killed = 1'b1; apply_stimulus(1); duck_killed = 1'b0;
    check_output("s2_hunt_fall", int'(hunt_start), 0);
    check_output("s2_dog_on", int'(dog_bird_enable), 1);
    check_output("s2_score_kept", int'(enemy_score), 1);
    apply_stimulus(7);
    check_output("s2_dog_held", int'(dog_bird_enable), 1);
    apply_stimulus(1);
    check_output("s2_dog_off", int'(dog_bird_enable), 0);

    // Kill on the cycle the flight timer expires.
    run_until_last_flight_cycle(40);
    duck_killed = 1'b1; apply_stimulus(1); duck_killed = 1'b0;
    check_output("s3_kill_wins", int'(dog_bird_enable), 1);
    check_output("s3_no_escape", int'(duck_escaped), 0);
    check_output("s3_score", int'(enemy_score), 1);
    check_output("s3_round", int'(round_number), 3);
    run_until_phase(PH_OVER, 60);
    check_output("s3_finished", int'(game_finished), 1);
    game_enable = 1'b0; apply_stimulus(1);
    check_output("s3_leave_score", int'(enemy_score), 1);

    // Three escapes, session end held, then leave the game.
    game_enable = 1'b1;
    game_enable_posedge = 1'b1; apply_stimulus(1); game_enable_posedge = 1'b0;
    check_output("s4_score_clear", int'(enemy_score), 0);
    apply_stimulus(2);
    dog_intro_done = 1'b1; apply_stimulus(1); dog_intro_done = 1'b0;
    run_until_phase(PH_OVER, 200);
    check_output("s4_score3", int'(enemy_score), 3);
    check_output("s4_finished", int'(game_finished), 1);
    apply_stimulus(5);
    check_output("s4_finished_held", int'(game_finished), 1);
    check_output("s4_round_frozen", int'(round_number), 3);
    game_enable = 1'b0; apply_stimulus(1);
    check_output("s4_idle_score", int'(enemy_score), 3);
    check_output("s4_idle_round", int'(round_number), 0);
    check_output("s4_idle_fin", int'(game_finished), 0);

    // Out of ammo in round 1 ends the session after the pause.
    game_enable = 1'b1;
    game_enable_posedge = 1'b1; apply_stimulus(1); game_enable_posedge = 1'b0;
    apply_stimulus(2);
    dog_intro_done = 1'b1; apply_stimulus(1); dog_intro_done = 1'b0;
    apply_stimulus(5);
    out_of_ammo = 1'b1; apply_stimulus(1);
    check_output("s5_escape", int'(duck_escaped), 1);
    check_output("s5_score", int'(enemy_score), 1);
    run_until_phase(PH_OVER, 20);
    check_output("s5_round1", int'(round_number), 1);
    check_output("s5_finished", int'(game_finished), 1);
    out_of_ammo = 1'b0;
    game_enable = 1'b0; apply_stimulus(1);

    // Reset mid-celebration, abort mid-flight, fresh restart.
    game_enable = 1'b1;
    game_enable_posedge = 1'b1; apply_stimulus(1); game_enable_posedge = 1'b0;
    dog_intro_done = 1'b1; apply_stimulus(1); dog_intro_done = 1'b0;
    apply_stimulus(3);
    duck_killed = 1'b1; apply_stimulus(1); duck_killed = 1'b0;
    apply_stimulus(3);
    check_output("s6_dog_before_rst", int'(dog_bird_enable), 1);
    rst = 1'b1; apply_stimulus(1); rst = 1'b0;
    check_all_zero("s6_rst");
    game_enable_posedge = 1'b1; apply_stimulus(1); game_enable_posedge = 1'b0;
    dog_intro_done = 1'b1; apply_stimulus(1); dog_intro_done = 1'b0;
    out_of_ammo = 1'b1; apply_stimulus(1); out_of_ammo = 1'b0;
    run_until_phase(PH_FLY, 20);
    apply_stimulus(3);
    check_output("s6_hunt_before_drop", int'(hunt_start), 1);
    game_enable = 1'b0; apply_stimulus(1);
    check_output("s6_drop_hunt", int'(hunt_start), 0);
    check_output("s6_drop_score", int'(enemy_score), 1);
    game_enable = 1'b1;
    game_enable_posedge = 1'b1; apply_stimulus(1); game_enable_posedge = 1'b0;
    check_output("s6_restart_score", int'(enemy_score), 0);
    check_output("s6_restart_round", int'(round_number), 1);

    // Random traffic, including stray start pulses and drops of game_enable.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0) game_enable = 1'b0;
      else if (!game_enable && $urandom_range(0, 3) == 0) game_enable = 1'b1;
      game_enable_posedge = ($urandom_range(0, 9) == 0);
      dog_intro_done      = ($urandom_range(0, 5) == 0);
      duck_killed         = ($urandom_range(0, 24) == 0);
      out_of_ammo         = ($urandom_range(0, 39) == 0);
      apply_stimulus(1);
    end
    rst = 1'b0; game_enable_posedge = 1'b0; dog_intro_done = 1'b0;
    duck_killed = 1'b0; out_of_ammo = 1'b0;
    apply_stimulus(2);
    check_output("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
